// File: rtl/uart_frame_parser_if.sv
// Byte-stream and frame-presentation signals between the UART receive path,
// the frame parser and the command logic that consumes held frames.
interface uart_frame_parser_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      rx_data;
  logic            rx_data_ready;
  logic            clear_rx;
  logic            frame_valid;
  logic [ADDR_W:0] frame_len;
  logic            frame_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]      rd_data;
  logic            frame_error;
  logic [1:0]      err_code;
  logic            busy;

  modport master (
    output rx_data, rx_data_ready, frame_ack, rd_addr,
    input  clear_rx, frame_valid, frame_len, rd_data, frame_error, err_code, busy
  );

  modport slave (
    input  rx_data, rx_data_ready, frame_ack, rd_addr,
    output clear_rx, frame_valid, frame_len, rd_data, frame_error, err_code, busy
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload/CHK/EOF frames from a UART byte stream, buffers the
// payload and holds a validated frame until the consumer acknowledges it.
module uart_frame_parser #(
  parameter int         ADDR_W         = 4,
  parameter logic [7:0] SOF_BYTE       = 8'hFE,
  parameter logic [7:0] EOF_BYTE       = 8'hEF,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  uart_frame_parser_if.slave bus
);
  localparam int MAX_LEN = 2**ADDR_W;
  localparam int TW      = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_EOF, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic              clear_rx_q, clear_rx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   frame_len_q, frame_len_d;
  logic [7:0]        chk_q, chk_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_error_q, frame_error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [7:0]        pbuf_q [MAX_LEN];

  logic              accept, active, timeout, len_ok, wr_en;
  logic [ADDR_W:0]   idx_inc;

  assign accept  = bus.rx_data_ready && !clear_rx_q && (state_q != S_HOLD);
  assign active  = (state_q == S_LEN) || (state_q == S_PAYLOAD) ||
                   (state_q == S_CHK) || (state_q == S_EOF);
  // An accepted byte takes priority over an expiring counter.
  assign timeout = active && !accept && (tmo_q == TW'(TIMEOUT_CYCLES - 2));
  assign len_ok  = (bus.rx_data != 8'd0) && (int'(bus.rx_data) <= MAX_LEN);
  assign idx_inc = idx_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    chk_d         = chk_q;
    frame_valid_d = frame_valid_q;
    frame_len_d   = frame_len_q;
    frame_error_d = 1'b0;
    err_code_d    = err_code_q;
    wr_en         = 1'b0;
    rd_data_d     = pbuf_q[bus.rd_addr];

    clear_rx_d = clear_rx_q;
    if (accept)                  clear_rx_d = 1'b1;
    else if (!bus.rx_data_ready) clear_rx_d = 1'b0;

    case (state_q)
      S_IDLE: if (accept && bus.rx_data == SOF_BYTE) state_d = S_LEN;
      S_LEN: if (accept) begin
        if (len_ok) begin
          len_d   = (ADDR_W+1)'(bus.rx_data);
          chk_d   = bus.rx_data;
          idx_d   = '0;
          state_d = S_PAYLOAD;
        end else begin
          state_d = S_IDLE; frame_error_d = 1'b1; err_code_d = 2'd0;
        end
      end
      S_PAYLOAD: if (accept) begin
        wr_en = 1'b1;
        chk_d = chk_q ^ bus.rx_data;
        idx_d = idx_inc;
        if (idx_inc == len_q) state_d = S_CHK;
      end
      S_CHK: if (accept) begin
        if (bus.rx_data == chk_q) state_d = S_EOF;
        else begin
          state_d = S_IDLE; frame_error_d = 1'b1; err_code_d = 2'd1;
        end
      end
      S_EOF: if (accept) begin
        if (bus.rx_data == EOF_BYTE) begin
          state_d       = S_HOLD;
          frame_valid_d = 1'b1;
          frame_len_d   = len_q;
        end else begin
          state_d = S_IDLE; frame_error_d = 1'b1; err_code_d = 2'd2;
        end
      end
      S_HOLD: if (bus.frame_ack) begin
        frame_valid_d = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d = S_IDLE; frame_error_d = 1'b1; err_code_d = 2'd3;
    end

    tmo_d = (active && !accept && state_d != S_IDLE) ? tmo_q + TW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      clear_rx_q    <= 1'b0;
      len_q         <= '0;
      idx_q         <= '0;
      chk_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      frame_error_q <= 1'b0;
      err_code_q    <= '0;
      tmo_q         <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      clear_rx_q    <= clear_rx_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      frame_error_q <= frame_error_d;
      err_code_q    <= err_code_d;
      tmo_q         <= tmo_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Payload storage carries no reset; contents are meaningful only up to frame_len.
  always_ff @(posedge clk) begin
    if (wr_en) pbuf_q[idx_q[ADDR_W-1:0]] <= bus.rx_data;
  end

  assign bus.clear_rx    = clear_rx_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.frame_error = frame_error_q;
  assign bus.err_code    = err_code_q;
  assign bus.busy        = active;
endmodule
